// File: rtl/mc_defs.sv
// mc_defs: shared encodings for the multi-cycle MIPS sequencing controller.
// Holds the state encoding, ALU op / NPC mode / mux-select codes, the
// opcode and func constants, the decoded instruction class, and the
// bundle of control outputs the controller drives each cycle.
package mc_defs;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    RTYPE_ADD,
    RTYPE_SUB,
    ORI,
    LUI,
    LW,
    SW,
    BEQ,
    JAL,
    JR,
    NOP
  } instr_class_t;

  // ALU operations
  localparam logic [5:0] ALU_ADD   = 6'd0;
  localparam logic [5:0] ALU_SUB   = 6'd1;
  localparam logic [5:0] ALU_OR    = 6'd2;
  localparam logic [5:0] ALU_LUI   = 6'd3;
  localparam logic [5:0] ALU_EQ    = 6'd4;
  localparam logic [5:0] ALU_PASSA = 6'd5;

  // NPC modes
  localparam logic [2:0] MODE_PC4    = 3'd0;
  localparam logic [2:0] MODE_BRANCH = 3'd1;
  localparam logic [2:0] MODE_JIDX   = 3'd2;
  localparam logic [2:0] MODE_ALU    = 3'd3;

  // ALU A select
  localparam logic [2:0] A_RDATA1 = 3'd0;
  localparam logic [2:0] A_PC     = 3'd1;

  // ALU B select
  localparam logic [2:0] B_RDATA2 = 3'd0;
  localparam logic [2:0] B_ZEXT   = 3'd1;
  localparam logic [2:0] B_SEXT   = 3'd2;
  localparam logic [2:0] B_FOUR   = 3'd3;

  // Register write target / data selects
  localparam logic [2:0] WT_RD  = 3'd0;
  localparam logic [2:0] WT_RT  = 3'd1;
  localparam logic [2:0] WT_RA  = 3'd2;
  localparam logic [2:0] WD_ALU = 3'd0;
  localparam logic [2:0] WD_MEM = 3'd1;

  // Opcodes and R-type function codes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  // Every control output the controller drives in one cycle.
  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    logic       grf_we;
    logic       mem_write;
    logic       mem_read;
    logic       instr_done;
    logic [2:0] a_sel;
    logic [2:0] b_sel;
    logic [2:0] wt_sel;
    logic [2:0] wd_sel;
    logic [5:0] alu_op;
    logic [2:0] mode;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // ALU operand selects and operation for a class's execute step. Also
  // reused in MEM/WB so the per-cycle ALU register keeps the same value
  // while the memory access or write-back completes.
  function automatic ctrl_t alu_setup(input instr_class_t c);
    ctrl_t r;
    r        = CTRL_IDLE;
    r.a_sel  = A_RDATA1;
    r.b_sel  = B_RDATA2;
    r.alu_op = ALU_ADD;
    case (c)
      RTYPE_SUB: r.alu_op = ALU_SUB;
      ORI: begin
        r.b_sel  = B_ZEXT;
        r.alu_op = ALU_OR;
      end
      LUI: begin
        r.b_sel  = B_ZEXT;
        r.alu_op = ALU_LUI;
      end
      LW, SW:    r.b_sel  = B_SEXT;
      BEQ:       r.alu_op = ALU_EQ;
      JR:        r.alu_op = ALU_PASSA;
      default:   ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_class.sv
// instr_class: purely combinational opcode/func decoder.
// Ports:
//   opcode  in  6  instruction opcode field
//   func    in  6  R-type function field
//   iclass  out    decoded instruction class (NOP for anything unsupported)
module instr_class
  import mc_defs::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   func,
  output instr_class_t iclass
);

  // NOTE: every always_comb output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    iclass = NOP;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: iclass = RTYPE_ADD;
          FN_SUBU: iclass = RTYPE_SUB;
          FN_JR:   iclass = JR;
          default: iclass = NOP;
        endcase
      end
      OP_ORI:  iclass = ORI;
      OP_LUI:  iclass = LUI;
      OP_LW:   iclass = LW;
      OP_SW:   iclass = SW;
      OP_BEQ:  iclass = BEQ;
      OP_JAL:  iclass = JAL;
      default: iclass = NOP;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle sequencing controller for the MIPS datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath's mux selects, ALU op, NPC mode and write enables. Outputs are
// combinational in the current state and the decoded instruction class.
// Ports:
//   clk, reset            clock (rising edge) and async active-high reset
//   opcode, func          instruction fields from the IR splitter
//   logicOutput           ALU compare result (resolved inside the NPC unit)
//   memReady              memory completed the current access
//   irWE, pcWE, grfWE     IR / PC / register-file write enables
//   memWrite, memRead     data memory requests (MEM cycle only)
//   AChoose, BChoose      ALU operand selects
//   wtChoose, wdataChoose register write target / data selects
//   aluOp, mode           ALU operation and NPC mode
//   state                 current state, for debug
//   instrDone             pulse in each instruction's final cycle
module mc_controller
  import mc_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       logicOutput,
  input  logic       memReady,
  output logic       irWE,
  output logic       pcWE,
  output logic       grfWE,
  output logic       memWrite,
  output logic       memRead,
  output logic [2:0] AChoose,
  output logic [2:0] BChoose,
  output logic [2:0] wtChoose,
  output logic [2:0] wdataChoose,
  output logic [5:0] aluOp,
  output logic [2:0] mode,
  output logic [2:0] state,
  output logic       instrDone
);

  instr_class_t iclass;
  state_t       state_q;
  ctrl_t        ctrl;
  ctrl_t        ctrl_out;

  instr_class u_instr_class (
    .opcode (opcode),
    .func   (func),
    .iclass (iclass)
  );

  // The branch decision is taken by the NPC unit in branch mode; the
  // controller asserts the same controls whether or not beq is taken.
  logic unused_logic_output;
  assign unused_logic_output = logicOutput;

  // NOTE: state is sequential, so it is updated with non-blocking
  // assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:  state_q <= DECODE;
        DECODE: begin
          case (iclass)
            NOP:     state_q <= FETCH;
            JAL:     state_q <= WB;
            default: state_q <= EXEC;
          endcase
        end
        EXEC: begin
          case (iclass)
            RTYPE_ADD, RTYPE_SUB, ORI, LUI: state_q <= WB;
            LW, SW:                         state_q <= MEM;
            default:                        state_q <= FETCH;
          endcase
        end
        MEM: begin
          // Hold until the memory signals completion.
          if (memReady) begin
            state_q <= (iclass == LW) ? WB : FETCH;
          end
        end
        WB:      state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end

  always_comb begin
    ctrl = CTRL_IDLE;
    case (state_q)
      FETCH: ctrl.ir_we = 1'b1;

      DECODE: begin
        if (iclass == NOP) begin
          ctrl.pc_we      = 1'b1;
          ctrl.instr_done = 1'b1;
        end
      end

      EXEC: begin
        ctrl = alu_setup(iclass);
        if (iclass == BEQ || iclass == JR) begin
          ctrl.mode       = (iclass == BEQ) ? MODE_BRANCH : MODE_ALU;
          ctrl.pc_we      = 1'b1;
          ctrl.instr_done = 1'b1;
        end
      end

      MEM: begin
        ctrl           = alu_setup(iclass);
        ctrl.mem_read  = (iclass == LW);
        ctrl.mem_write = (iclass == SW);
        // sw finishes in MEM, but only once the write has been accepted.
        if (iclass == SW && memReady) begin
          ctrl.pc_we      = 1'b1;
          ctrl.instr_done = 1'b1;
        end
      end

      WB: begin
        if (iclass == JAL) begin
          // Link value pc+4 goes through the ALU into $31.
          ctrl.a_sel  = A_PC;
          ctrl.b_sel  = B_FOUR;
          ctrl.alu_op = ALU_ADD;
          ctrl.wt_sel = WT_RA;
          ctrl.wd_sel = WD_ALU;
          ctrl.mode   = MODE_JIDX;
        end else begin
          ctrl        = alu_setup(iclass);
          ctrl.wt_sel = (iclass == RTYPE_ADD || iclass == RTYPE_SUB) ? WT_RD : WT_RT;
          ctrl.wd_sel = (iclass == LW) ? WD_MEM : WD_ALU;
        end
        ctrl.grf_we     = 1'b1;
        ctrl.pc_we      = 1'b1;
        ctrl.instr_done = 1'b1;
      end

      default: ctrl = CTRL_IDLE;
    endcase
  end

  // Reset overrides everything combinationally, so an instruction aborted
  // mid-flight can never complete a PC update or register write.
  assign ctrl_out = reset ? CTRL_IDLE : ctrl;

  assign irWE        = ctrl_out.ir_we;
  assign pcWE        = ctrl_out.pc_we;
  assign grfWE       = ctrl_out.grf_we;
  assign memWrite    = ctrl_out.mem_write;
  assign memRead     = ctrl_out.mem_read;
  assign instrDone   = ctrl_out.instr_done;
  assign AChoose     = ctrl_out.a_sel;
  assign BChoose     = ctrl_out.b_sel;
  assign wtChoose    = ctrl_out.wt_sel;
  assign wdataChoose = ctrl_out.wd_sel;
  assign aluOp       = ctrl_out.alu_op;
  assign mode        = ctrl_out.mode;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for mc_controller. A driver issues
// instructions (directed, then random) and pushes the expected per-cycle
// outputs, derived from the instruction-class rules, into a queue; a
// monitor on the falling edge pops and compares.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, func;
  logic       logicOutput, memReady;
  logic       irWE, pcWE, grfWE, memWrite, memRead, instrDone;
  logic [2:0] AChoose, BChoose, wtChoose, wdataChoose, mode, state;
  logic [5:0] aluOp;

  int checks = 0;
  int errors = 0;
  bit running = 1'b0;

  mc_controller dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .func        (func),
    .logicOutput (logicOutput),
    .memReady    (memReady),
    .irWE        (irWE),
    .pcWE        (pcWE),
    .grfWE       (grfWE),
    .memWrite    (memWrite),
    .memRead     (memRead),
    .AChoose     (AChoose),
    .BChoose     (BChoose),
    .wtChoose    (wtChoose),
    .wdataChoose (wdataChoose),
    .aluOp       (aluOp),
    .mode        (mode),
    .state       (state),
    .instrDone   (instrDone)
  );

  always #5 clk = ~clk;

  // Instruction kinds of the reference model
  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4;
  localparam int K_SW = 5, K_BEQ = 6, K_JAL = 7, K_JR = 8, K_NOP = 9;

  typedef struct {
    logic [29:0] exp;
    logic [29:0] mask;
    string       tag;
  } sb_t;

  typedef struct {
    int   st;
    logic rdy;
    bit   last;
  } cyc_t;

  sb_t sb_q[$];
  sb_t mon_e;

  function automatic logic [29:0] pack(int st, bit ir, bit pc, bit grf, bit mw, bit mr,
                                       bit dn, int md, int wt, int wd, int a, int b, int op);
    return {3'(st), ir, pc, grf, mw, mr, dn, 3'(md), 3'(wt), 3'(wd), 3'(a), 3'(b), 6'(op)};
  endfunction

  function automatic logic [29:0] got_vec();
    return {state, irWE, pcWE, grfWE, memWrite, memRead, instrDone,
            mode, wtChoose, wdataChoose, AChoose, BChoose, aluOp};
  endfunction

  task automatic check(input string name, input logic [29:0] got, input logic [29:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  function automatic int ref_kind(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:   return (fn == 6'h21) ? K_ADDU : (fn == 6'h23) ? K_SUBU :
                      (fn == 6'h08) ? K_JR : K_NOP;
      6'h0d:   return K_ORI;
      6'h0f:   return K_LUI;
      6'h23:   return K_LW;
      6'h2b:   return K_SW;
      6'h04:   return K_BEQ;
      6'h03:   return K_JAL;
      default: return K_NOP;
    endcase
  endfunction

  // Called at posedge+1 of the instruction's FETCH cycle; returns at
  // posedge+1 of the following cycle (or just after the monitor sample of
  // entry abort_after, when that is >= 0). stalls < 0 means random.
  task automatic run_instr(input logic [31:0] instr, input int stalls, input logic lo,
                           input int abort_after);
    int    kind;
    int    seq[$];
    cyc_t  cyc[$];
    int    n;
    int    st;
    bit    alu_chk, b_chk, wb;
    int    a_v, b_v, op_v, wt_v, wd_v, md;
    logic [31:0] junk;
    sb_t   e;

    kind = ref_kind(instr[31:26], instr[5:0]);
    case (kind)
      K_ADDU, K_SUBU, K_ORI, K_LUI: seq = '{0, 1, 2, 4};
      K_LW:                         seq = '{0, 1, 2, 3, 4};
      K_SW:                         seq = '{0, 1, 2, 3};
      K_BEQ, K_JR:                  seq = '{0, 1, 2};
      K_JAL:                        seq = '{0, 1, 4};
      default:                      seq = '{0, 1};
    endcase
    foreach (seq[k]) begin
      if (seq[k] == 3) begin
        n = (stalls < 0) ? int'($urandom_range(0, 3)) : stalls;
        repeat (n) cyc.push_back('{3, 1'b0, 1'b0});
        cyc.push_back('{3, 1'b1, 1'b0});
      end else begin
        cyc.push_back('{seq[k], 1'($urandom_range(0, 1)), 1'b0});
      end
    end
    cyc[cyc.size() - 1].last = 1'b1;

    case (kind)
      K_ADDU:      begin b_v = 0; op_v = 0; wt_v = 0; wd_v = 0; end
      K_SUBU:      begin b_v = 0; op_v = 1; wt_v = 0; wd_v = 0; end
      K_ORI:       begin b_v = 1; op_v = 2; wt_v = 1; wd_v = 0; end
      K_LUI:       begin b_v = 1; op_v = 3; wt_v = 1; wd_v = 0; end
      K_LW:        begin b_v = 2; op_v = 0; wt_v = 1; wd_v = 1; end
      K_SW:        begin b_v = 2; op_v = 0; wt_v = 0; wd_v = 0; end
      K_BEQ:       begin b_v = 0; op_v = 4; wt_v = 0; wd_v = 0; end
      K_JR:        begin b_v = 0; op_v = 5; wt_v = 0; wd_v = 0; end
      K_JAL:       begin b_v = 3; op_v = 0; wt_v = 2; wd_v = 0; end
      default:     begin b_v = 0; op_v = 0; wt_v = 0; wd_v = 0; end
    endcase
    a_v = (kind == K_JAL) ? 1 : 0;

    foreach (cyc[i]) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      if (i == 0) begin
        // IR still holds the previous word during FETCH.
        junk   = $urandom;
        opcode = junk[31:26];
        func   = junk[5:0];
      end else begin
        opcode = instr[31:26];
        func   = instr[5:0];
      end
      memReady    = cyc[i].rdy;
      logicOutput = lo;

      st      = cyc[i].st;
      wb      = (st == 4);
      alu_chk = (st == 2 && kind != K_JAL && kind != K_NOP) || (st == 4 && kind == K_JAL);
      b_chk   = alu_chk && kind != K_JR;
      md      = (st == 2 && kind == K_BEQ) ? 1 : (st == 2 && kind == K_JR) ? 3 :
                (st == 4 && kind == K_JAL) ? 2 : 0;
      e.exp  = pack(st, st == 0, cyc[i].last, wb, st == 3 && kind == K_SW,
                    st == 3 && kind == K_LW, cyc[i].last, md,
                    wb ? wt_v : 0, wb ? wd_v : 0, alu_chk ? a_v : 0,
                    b_chk ? b_v : 0, alu_chk ? op_v : 0);
      e.mask = pack(7, 1, 1, 1, 1, 1, 1, 7, wb ? 7 : 0, wb ? 7 : 0,
                    alu_chk ? 7 : 0, b_chk ? 7 : 0, alu_chk ? 63 : 0);
      e.tag  = $sformatf("instr_%08h_cyc%0d", instr, i);
      sb_q.push_back(e);
      if (i == abort_after) begin
        #6;
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0:  return 32'h01095021;            // addu
      1:  return 32'h01095023;            // subu
      2:  return 32'h34081234;            // ori
      3:  return 32'h3c081234;            // lui
      4:  return 32'h8d090004;            // lw
      5:  return 32'had090000;            // sw
      6:  return 32'h11090003;            // beq
      7:  return 32'h0c000c00;            // jal
      8:  return 32'h03e00008;            // jr
      9:  return {6'h00, w[25:0]};        // R-type, random func
      default: return w;                  // arbitrary word
    endcase
  endfunction

  // Monitor: compare whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    if (running && !reset) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got output with no expectation queued at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check(mon_e.tag, got_vec() & mon_e.mask, mon_e.exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    opcode      = 6'h23;
    func        = 6'h00;
    logicOutput = 1'b0;
    memReady    = 1'b0;
    #2;
    check("reset_async", got_vec(), '0);
    @(posedge clk);
    #1;
    check("reset_hold", got_vec(), '0);
    reset   = 1'b0;
    running = 1'b1;

    // Directed cases
    run_instr(32'h34081234, 0, 1'b0, -1);   // ori
    run_instr(32'h8d090004, 2, 1'b0, -1);   // lw, two stall cycles
    run_instr(32'had090000, 0, 1'b0, -1);   // sw
    run_instr(32'h11090003, 0, 1'b1, -1);   // beq taken
    run_instr(32'h11090003, 0, 1'b0, -1);   // beq not taken
    run_instr(32'h0c000c00, 0, 1'b0, -1);   // jal
    run_instr(32'had090000, 3, 1'b1, -1);   // sw, stalled

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      run_instr(pick_instr(), -1, 1'($urandom_range(0, 1)), -1);
    end

    // Reset in the middle of a stalled lw MEM cycle
    run_instr(32'h8d090004, 3, 1'b0, 3);
    reset = 1'b1;
    #1;
    check("reset_mid_mem", got_vec(), '0);
    @(posedge clk);
    #1;
    check("reset_mid_mem_hold", got_vec(), '0);
    reset    = 1'b0;
    memReady = 1'b1;
    run_instr(32'hfc000000, 0, 1'b0, -1);   // opcode 0x3f -> NOP

    for (int n = 0; n < 20; n++) begin
      run_instr(pick_instr(), -1, 1'($urandom_range(0, 1)), -1);
    end

    running = 1'b0;
    check("sb_drain", 30'(sb_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
